// File: rtl/arb_pkg.sv
// Shared types and sizing for the six-way request arbiter.
package arb_pkg;

  localparam int NUM_REQ = 6;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set eff bit at or above ptr, wrapping 5->0.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eff,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    index,
  output logic               valid
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    pick  = '0;
    index = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : 3'(sum);
      if (!valid && eff[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        index     = idx;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_6.sv
// Six-requester round-robin arbiter with registered one-hot grant.
// Optional hold-time limit is built only when ARB_TIMEOUT_EN is defined.
module req_arbiter_6
  import arb_pkg::*;
#(
  parameter logic [5:0] RequestInvertMask = 6'b000000,
  parameter int         TimeoutCycles     = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NUM_REQ-1:0]  Req,
  input  logic [NUM_REQ-1:0]  Req_Mask,
  input  logic                Done,
  output logic [NUM_REQ-1:0]  Grant,
  output logic [ID_W-1:0]     Grant_Id,
  output logic                Busy,
  output logic                Any_Req,
  output logic                Timeout
);

  arb_state_e          state;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  eff;
  logic [NUM_REQ-1:0]  pick;
  logic [ID_W-1:0]     pick_id;
  logic                pick_valid;
  logic                owner_eff;
  logic                tmo_hit;

  assign eff       = (Req ^ RequestInvertMask) & Req_Mask;
  assign Any_Req   = |eff;
  assign owner_eff = eff[Grant_Id];

  rr_priority_pick u_pick (
    .eff   (eff),
    .ptr   (ptr),
    .pick  (pick),
    .index (pick_id),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TimeoutCycles - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign tmo_hit = (state == GRANT) && (hold_cnt == TMO_LAST);
  assign Timeout = timeout_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (state == IDLE && pick_valid) begin
        hold_cnt <= '0;
      end else if (state == GRANT && !tmo_hit) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      Grant    <= '0;
      Grant_Id <= '0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            Grant    <= pick;
            Grant_Id <= pick_id;
            Busy     <= 1'b1;
            ptr      <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
          end
        end
        GRANT: begin
          // Other requesters never preempt; only the owner or the limit ends a grant.
          if (Done || !owner_eff || tmo_hit) begin
            state    <= RELEASE;
            Grant    <= '0;
            Grant_Id <= '0;
            Busy     <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          Grant    <= '0;
          Grant_Id <= '0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter_6.sv
// Directed bench for req_arbiter_6: main instance with default mask, second with inverted bit 1.
module tb_req_arbiter_6;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [5:0] req, req_mask;
  logic       done;
  logic [5:0] grant;
  logic [2:0] grant_id;
  logic       busy, any_req, timeout;

  logic [5:0] req_i, req_mask_i;
  logic       done_i;
  logic [5:0] grant_i;
  logic [2:0] grant_id_i;
  logic       busy_i, any_req_i, timeout_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  req_arbiter_6 dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Req      (req),
    .Req_Mask (req_mask),
    .Done     (done),
    .Grant    (grant),
    .Grant_Id (grant_id),
    .Busy     (busy),
    .Any_Req  (any_req),
    .Timeout  (timeout)
  );

  req_arbiter_6 #(.RequestInvertMask(6'b000010), .TimeoutCycles(4)) dut_inv (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Req      (req_i),
    .Req_Mask (req_mask_i),
    .Done     (done_i),
    .Grant    (grant_i),
    .Grant_Id (grant_id_i),
    .Busy     (busy_i),
    .Any_Req  (any_req_i),
    .Timeout  (timeout_i)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n    = 1'b0;
    req        = 6'b000000;
    req_mask   = 6'b111111;
    done       = 1'b0;
    req_i      = 6'b000010;
    req_mask_i = 6'b111111;
    done_i     = 1'b0;
    #12;
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_id", 32'(grant_id), 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    check_val("rst_inv_any", 32'(any_req_i), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Done in IDLE with no requests does nothing
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("idle_done_busy", 32'(busy), 32'h0);
    check_val("idle_any", 32'(any_req), 32'h0);

    // First grant after reset favours requester 0
    req = 6'b100001;
    #1;
    check_val("any_req", 32'(any_req), 32'h1);
    tick();
    check_val("g0_grant", 32'(grant), 32'h01);
    check_val("g0_id", 32'(grant_id), 32'h0);
    check_val("g0_busy", 32'(busy), 32'h1);
    tick();
    tick();
    check_val("g0_hold", 32'(grant), 32'h01);

    // Done -> RELEASE, IDLE, then wrap to requester 5
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("rel_grant", 32'(grant), 32'h0);
    check_val("rel_busy", 32'(busy), 32'h0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("idle_grant", 32'(grant), 32'h0);
    tick();
    check_val("g5_grant", 32'(grant), 32'h20);
    check_val("g5_id", 32'(grant_id), 32'h5);

    // Owner 5 drops, requester 2 waiting: two empty cycles then 2
    req = 6'b000100;
    tick();
    check_val("drop_rel", 32'(grant), 32'h0);
    tick();
    check_val("drop_idle", 32'(grant), 32'h0);
    tick();
    check_val("g2_grant", 32'(grant), 32'h04);
    check_val("g2_id", 32'(grant_id), 32'h2);

    // Masking the owner releases it; ptr=3 so requester 3 beats 0
    req_mask = 6'b111011;
    tick();
    check_val("mask_rel", 32'(grant), 32'h0);
    req      = 6'b001001;
    req_mask = 6'b111111;
    tick();
    tick();
    check_val("g3_grant", 32'(grant), 32'h08);
    check_val("g3_id", 32'(grant_id), 32'h3);

    // ptr=4, requests 0 and 1: search 4,5,0 -> 0
    req  = 6'b000011;
    done = 1'b1;
    tick();
    done = 1'b0;
    check_val("wrap_rel", 32'(grant), 32'h0);
    tick();
    tick();
    check_val("wrap_grant", 32'(grant), 32'h01);

`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) tick();
    check_val("hold_forever", 32'(grant), 32'h01);
    check_val("hold_no_tmo", 32'(timeout), 32'h0);
`endif

    // Asynchronous reset mid-grant
    #3;
    Reset_n = 1'b0;
    #1;
    check_val("async_grant", 32'(grant), 32'h0);
    check_val("async_busy", 32'(busy), 32'h0);
    @(negedge Clock);
    Reset_n    = 1'b1;
    req        = 6'b111111;
    req_i      = 6'b000000;
    req_mask_i = 6'b111111;
    #1;
    check_val("inv_any", 32'(any_req_i), 32'h1);
    tick();
    check_val("post_rst_grant", 32'(grant), 32'h01);
    check_val("inv_grant", 32'(grant_i), 32'h02);
    check_val("inv_id", 32'(grant_id_i), 32'h1);

    // Inverted instance: only requester 3 effective; owner 1 loses eff
    req_i      = 6'b001010;
    req_mask_i = 6'b001000;
    tick();
    check_val("inv_rel", 32'(grant_i), 32'h0);
    tick();
    tick();
    check_val("g3i_grant", 32'(grant_i), 32'h08);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("tmo_hold", 32'(grant_i), 32'h08);
      check_val("tmo_quiet", 32'(timeout_i), 32'h0);
    end
    tick();
    check_val("tmo_rel", 32'(grant_i), 32'h0);
    check_val("tmo_pulse", 32'(timeout_i), 32'h1);
    tick();
    check_val("tmo_idle", 32'(grant_i), 32'h0);
    check_val("tmo_pulse_end", 32'(timeout_i), 32'h0);
    tick();
    check_val("tmo_regrant", 32'(grant_i), 32'h08);
`else
    for (int i = 0; i < 6; i++) tick();
    check_val("notmo_hold", 32'(grant_i), 32'h08);
    check_val("notmo_flag", 32'(timeout_i), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
